// File: rtl/mips_rtype_exec_unit_if.sv
// Issue/retire bus of the R-type execution unit: valid/ready instruction input
// and valid/ready result output.
interface mips_rtype_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_ovf;
    logic            out_illegal;

    // master: the issue/retire side driving instructions and taking results
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_ovf, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_ovf, out_illegal
    );
endinterface

// File: rtl/mips_rtype_exec_unit.sv
// Two-stage MIPS R-type execution unit: S1 instruction latch with register read
// and result forwarding, S2 result register driving the retire port.
module mips_rtype_exec_unit #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_rtype_exec_unit_if.slave bus,
    input  logic                 clr_sticky,
    output logic                 ovf_sticky,
    output logic [CNT_W-1:0]     retired_count
);
    localparam int          SW      = $clog2(XLEN);
    localparam int          RW      = $clog2(NREGS);
    localparam logic [31:0] NREGS_U = 32'(NREGS);

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    logic            s1_valid_q;
    logic [31:0]     s1_instr_q;
    logic            out_valid_q;
    logic [XLEN-1:0] out_result_q;
    logic [4:0]      out_rd_q;
    logic            out_ovf_q;
    logic            out_illegal_q;
    logic            sticky_q;
    logic [CNT_W-1:0] count_q;
    logic [XLEN-1:0] rf_q [NREGS];

    logic stall, s1_load, s2_load, retire, s2_writes;

    assign stall     = out_valid_q & ~bus.out_ready;
    assign s1_load   = bus.in_valid & bus.in_ready;
    assign s2_load   = s1_valid_q & ~stall;
    assign retire    = out_valid_q & bus.out_ready;
    assign s2_writes = ~out_ovf_q & ~out_illegal_q;

    assign bus.in_ready    = ~stall | ~s1_valid_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = out_result_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_ovf     = out_ovf_q;
    assign bus.out_illegal = out_illegal_q;
    assign ovf_sticky      = sticky_q;
    assign retired_count   = count_q;

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd, shamt;
    assign op    = s1_instr_q[31:26];
    assign rs    = s1_instr_q[25:21];
    assign rt    = s1_instr_q[20:16];
    assign rd    = s1_instr_q[15:11];
    assign shamt = s1_instr_q[10:6];
    assign funct = s1_instr_q[5:0];

    logic regs_ok;
    assign regs_ok = ({27'd0, rs} < NREGS_U) && ({27'd0, rt} < NREGS_U) &&
                     ({27'd0, rd} < NREGS_U);

    // Bypass the not-yet-written S2 result so dependent instructions need no bubble.
    logic            fwd_a, fwd_b;
    logic [XLEN-1:0] op_a, op_b;
    assign fwd_a = out_valid_q & s2_writes & (out_rd_q == rs);
    assign fwd_b = out_valid_q & s2_writes & (out_rd_q == rt);
    assign op_a  = (rs == 5'd0) ? '0 : (fwd_a ? out_result_q : rf_q[rs[RW-1:0]]);
    assign op_b  = (rt == 5'd0) ? '0 : (fwd_b ? out_result_q : rf_q[rt[RW-1:0]]);

    logic [SW-1:0]   sh_imm, sh_var;
    logic [XLEN-1:0] sum, diff;
    logic            lt_s, lt_u;
    assign sh_imm = SW'(shamt);
    assign sh_var = op_a[SW-1:0];
    assign sum    = op_a + op_b;
    assign diff   = op_a - op_b;
    assign lt_s   = $signed(op_a) < $signed(op_b);
    assign lt_u   = op_a < op_b;

    logic [XLEN-1:0] res_d;
    logic            ovf_d, ill_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        res_d = '0;
        ovf_d = 1'b0;
        ill_d = 1'b0;
        if (op != 6'd0 || !regs_ok) begin
            ill_d = 1'b1;
        end else begin
            unique case (funct)
                F_SLL:  res_d = op_b << sh_imm;
                F_SRL:  res_d = op_b >> sh_imm;
                F_SRA:  res_d = XLEN'($signed(op_b) >>> sh_imm);
                F_SLLV: res_d = op_b << sh_var;
                F_SRLV: res_d = op_b >> sh_var;
                F_SRAV: res_d = XLEN'($signed(op_b) >>> sh_var);
                F_ADD: begin
                    res_d = sum;
                    ovf_d = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
                end
                F_ADDU: res_d = sum;
                F_SUB: begin
                    res_d = diff;
                    ovf_d = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
                end
                F_SUBU: res_d = diff;
                F_AND:  res_d = op_a & op_b;
                F_OR:   res_d = op_a | op_b;
                F_XOR:  res_d = op_a ^ op_b;
                F_NOR:  res_d = ~(op_a | op_b);
                F_SLT:  res_d = {{(XLEN-1){1'b0}}, lt_s};
                F_SLTU: res_d = {{(XLEN-1){1'b0}}, lt_u};
                default: ill_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_instr_q <= '0;
        end else if (s1_load) begin
            s1_valid_q <= 1'b1;
            s1_instr_q <= bus.in_instr;
        end else if (s2_load) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_rd_q      <= '0;
            out_ovf_q     <= 1'b0;
            out_illegal_q <= 1'b0;
        end else if (s2_load) begin
            out_valid_q   <= 1'b1;
            out_result_q  <= res_d;
            out_rd_q      <= rd;
            out_ovf_q     <= ovf_d;
            out_illegal_q <= ill_d;
        end else if (retire) begin
            out_valid_q   <= 1'b0;
        end
    end

    // NOTE: the register file resets to identity values, so it must be built from
    // resettable flops rather than a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= XLEN'(i);
        end else if (retire && s2_writes && out_rd_q != 5'd0) begin
            rf_q[out_rd_q[RW-1:0]] <= out_result_q;
        end
    end

    // A retiring overflow beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (retire && out_ovf_q) sticky_q <= 1'b1;
            else if (clr_sticky)     sticky_q <= 1'b0;
            if (retire) count_q <= count_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_mips_rtype_exec_unit.sv
// Directed bench for mips_rtype_exec_unit: an in-order ISA model predicts each
// result into a scoreboard that a retire monitor pops and compares.
module tb_mips_rtype_exec_unit;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        ovf;
        logic        illegal;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr_sticky = 1'b0;
    logic             ovf_sticky;
    logic [CNT_W-1:0] retired_count;

    mips_rtype_exec_unit_if #(.XLEN(XLEN)) bus ();

    mips_rtype_exec_unit #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .clr_sticky   (clr_sticky),
        .ovf_sticky   (ovf_sticky),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    exp_t        sb_q[$];
    logic [31:0] mrf [NREGS];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_issued = 0;
    logic [31:0] last_result = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) mrf[i] = 32'(i);
    endtask

    // Sequential ISA semantics; overflow judged on the exact 64-bit signed value.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t        e;
        logic [4:0]  rs = ins[25:21];
        logic [4:0]  rt = ins[20:16];
        logic [4:0]  rd = ins[15:11];
        logic [4:0]  sh = ins[10:6];
        logic [31:0] a = mrf[rs];
        logic [31:0] b = mrf[rt];
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      wide;
        e = '0;
        e.rd = rd;
        if (ins[31:26] != 6'd0) e.illegal = 1'b1;
        else begin
            case (ins[5:0])
                6'h00: e.result = b << sh;
                6'h02: e.result = b >> sh;
                6'h03: e.result = 32'($signed(b) >>> sh);
                6'h04: e.result = b << a[4:0];
                6'h06: e.result = b >> a[4:0];
                6'h07: e.result = 32'($signed(b) >>> a[4:0]);
                6'h20: begin
                    wide = sa + sb;
                    e.result = wide[31:0];
                    e.ovf = (wide != longint'($signed(e.result)));
                end
                6'h21: e.result = a + b;
                6'h22: begin
                    wide = sa - sb;
                    e.result = wide[31:0];
                    e.ovf = (wide != longint'($signed(e.result)));
                end
                6'h23: e.result = a - b;
                6'h24: e.result = a & b;
                6'h25: e.result = a | b;
                6'h26: e.result = a ^ b;
                6'h27: e.result = ~(a | b);
                6'h2A: e.result = (sa < sb) ? 32'd1 : 32'd0;
                6'h2B: e.result = (a < b) ? 32'd1 : 32'd0;
                default: e.illegal = 1'b1;
            endcase
        end
        if (!e.illegal && !e.ovf && rd != 5'd0) mrf[rd] = e.result;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] instr);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 64'(bus.in_ready), 64'd1);
        if (bus.in_ready) begin
            sb_q.push_back(model(instr));
            n_issued++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            tick(1);
            n++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
    endtask

    // Retire monitor: scoreboard compare on each handshake, stability during stalls.
    logic        prev_stall = 1'b0;
    logic [39:0] prev_bus = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) prev_stall = 1'b0;
        else begin
            if (prev_stall)
                check("stall_hold", 64'({bus.out_valid, bus.out_result, bus.out_rd,
                                         bus.out_ovf, bus.out_illegal}), 64'(prev_bus));
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) check("sb_nonempty", 64'(sb_q.size()), 64'd1);
                else begin
                    e = sb_q.pop_front();
                    check("retire", 64'({bus.out_result, bus.out_rd, bus.out_ovf,
                                         bus.out_illegal}), 64'(e));
                    last_result = bus.out_result;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_bus = {bus.out_valid, bus.out_result, bus.out_rd, bus.out_ovf, bus.out_illegal};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b1;
        model_reset();

        // Reset values appear without any clock edge.
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_result", 64'(bus.out_result), 64'd0);
        check("rst_out_flags", 64'({bus.out_rd, bus.out_ovf, bus.out_illegal}), 64'd0);
        check("rst_sticky_cnt", 64'({ovf_sticky, retired_count}), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // sll r2,r1,1: one-cycle latency after acceptance.
        send(32'h00011040);
        check("lat_s1_only", 64'(bus.out_valid), 64'd0);
        tick(1);
        check("lat_out_valid", 64'(bus.out_valid), 64'd1);
        check("lat_out_result", 64'(bus.out_result), 64'd2);
        check("lat_out_rd", 64'(bus.out_rd), 64'd2);
        tick(1);
        check("lat_count", 64'(retired_count), 64'd1);

        // Back-to-back dependent chain with overflow and forwarding.
        send(rtype(5'd0, 5'd1, 5'd4, 5'd30, 6'h00));
        send(rtype(5'd4, 5'd4, 5'd5, 5'd0, 6'h20));
        send(rtype(5'd4, 5'd4, 5'd6, 5'd0, 6'h21));
        send(rtype(5'd0, 5'd6, 5'd7, 5'd31, 6'h03));
        send(rtype(5'd24, 5'd25, 5'd26, 5'd0, 6'h2B));
        send(rtype(5'd7, 5'd1, 5'd8, 5'd0, 6'h2A));
        drain();
        check("chain_slt", 64'(last_result), 64'd1);
        check("chain_sticky", 64'(ovf_sticky), 64'd1);
        send(rtype(5'd5, 5'd0, 5'd10, 5'd0, 6'h25));
        drain();
        check("r5_unwritten", 64'(last_result), 64'd5);
        check("chain_count", 64'(retired_count), 64'(CNT_W'(n_issued)));

        // Sticky clear, then overflow retiring in the same cycle as a clear.
        clr_sticky = 1'b1;
        tick(1);
        clr_sticky = 1'b0;
        check("sticky_cleared", 64'(ovf_sticky), 64'd0);
        bus.out_ready = 1'b0;
        send(rtype(5'd6, 5'd1, 5'd13, 5'd0, 6'h22));
        tick(1);
        bus.out_ready = 1'b1;
        clr_sticky = 1'b1;
        tick(1);
        clr_sticky = 1'b0;
        check("sticky_set_wins", 64'(ovf_sticky), 64'd1);

        // Two instructions queued behind a 3-cycle stall, the second dependent.
        c0 = n_issued;
        bus.out_ready = 1'b0;
        send(rtype(5'd1, 5'd3, 5'd11, 5'd0, 6'h22));
        send(rtype(5'd11, 5'd2, 5'd12, 5'd0, 6'h26));
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_out_rd", 64'({bus.out_valid, bus.out_rd}), 64'({1'b1, 5'd11}));
        tick(3);
        check("stall_in_ready_held", 64'(bus.in_ready), 64'd0);
        check("stall_count_held", 64'(retired_count), 64'(CNT_W'(c0)));
        bus.out_ready = 1'b1;
        tick(1);
        check("release_first", 64'({retired_count, bus.out_valid, bus.out_rd}),
              64'({CNT_W'(c0 + 1), 1'b1, 5'd12}));
        tick(1);
        check("release_second", 64'({retired_count, bus.out_valid}),
              64'({CNT_W'(c0 + 2), 1'b0}));
        check("xor_forwarded", 64'(last_result), 64'hFFFF_FFFC);

        // Remaining functions at full rate.
        send(rtype(5'd12, 5'd7, 5'd14, 5'd0, 6'h24));
        send(rtype(5'd0, 5'd0, 5'd15, 5'd0, 6'h27));
        send(rtype(5'd3, 5'd7, 5'd16, 5'd0, 6'h06));
        send(rtype(5'd3, 5'd6, 5'd17, 5'd0, 6'h07));
        send(rtype(5'd2, 5'd3, 5'd18, 5'd0, 6'h04));
        send(rtype(5'd0, 5'd1, 5'd19, 5'd0, 6'h23));
        send(rtype(5'd0, 5'd6, 5'd20, 5'd4, 6'h02));
        send(rtype(5'd1, 5'd7, 5'd21, 5'd0, 6'h2A));
        send(rtype(5'd1, 5'd7, 5'd22, 5'd0, 6'h2B));
        drain();

        // Illegal encodings and r0 writes.
        send(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F));
        send({6'h08, 5'd1, 5'd2, 5'd3, 11'd0});
        send(rtype(5'd1, 5'd1, 5'd0, 5'd0, 6'h20));
        send(rtype(5'd0, 5'd0, 5'd9, 5'd0, 6'h25));
        drain();
        check("r0_reads_zero", 64'(last_result), 64'd0);
        send(rtype(5'd3, 5'd0, 5'd23, 5'd0, 6'h25));
        drain();
        check("r3_unwritten", 64'(last_result), 64'd3);
        check("illegal_count", 64'(retired_count), 64'(CNT_W'(n_issued)));

        // Reset with S1 and S2 both full.
        bus.out_ready = 1'b0;
        send(rtype(5'd1, 5'd1, 5'd24, 5'd0, 6'h21));
        send(rtype(5'd24, 5'd1, 5'd25, 5'd0, 6'h21));
        check("full_before_rst", 64'({bus.out_valid, bus.in_ready}), 64'({1'b1, 1'b0}));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_state", 64'({ovf_sticky, retired_count, bus.in_ready}), 64'd1);
        sb_q.delete();
        model_reset();
        n_issued = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick(1);
        bus.out_ready = 1'b1;
        send(rtype(5'd24, 5'd0, 5'd27, 5'd0, 6'h25));
        send(rtype(5'd25, 5'd0, 5'd28, 5'd0, 6'h25));
        drain();
        check("r25_identity", 64'(last_result), 64'd25);
        check("post_rst_count", 64'(retired_count), 64'(CNT_W'(n_issued)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
